// File: rtl/param_code_detonator.sv
// Keypad code lock: arm, key in a BCD code, fire only after a matching check; repeated misses lock out until reset.
// Define CODE_PROG_EN to add the PROG state and a reprogrammable code register (default build uses DEFAULT_CODE only).
module param_code_detonator #(
    parameter int          DIGITS       = 4,
    parameter logic [31:0] DEFAULT_CODE = 32'h0000_2580,
    parameter int          MAX_TRIES    = 3,
    parameter int          TIMEOUT_CYC  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key_n,
    input  logic       arm,
    input  logic       disarm,
    input  logic       enter,
    input  logic       fire,
    input  logic       clear,
    input  logic       prog,
    output logic       ok_led,
    output logic       fire_led,
    output logic       err_led,
    output logic       buzzer,
    output logic       lock_led,
    output logic [3:0] digit_disp,
    output logic [3:0] digit_cnt
);
    localparam int BW = 4 * DIGITS;
    localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    CNT_FULL  = 4'(DIGITS);
    localparam logic [3:0]    TRIES_MAX = 4'(MAX_TRIES);

    typedef enum logic [3:0] {
        S_IDLE, S_ARMED, S_ENTRY, S_CHECK, S_OK, S_FIRE, S_ERROR, S_LOCKED, S_PROG
    } state_t;

    state_t        r_state, w_nextState;
    logic [9:0]    r_prevKey;
    logic [BW-1:0] r_buf, w_bufShift, w_code;
    logic [3:0]    r_cnt, r_disp, r_failCnt, w_failNext, w_digit;
    logic [IW-1:0] r_idleCnt;
    logic          r_ok, r_fire, r_err, r_lock;
    logic          w_keyEvent, w_accept, w_bufFull, w_timeout, w_codeMatch, w_clearBuf;

`ifdef CODE_PROG_EN
    localparam bit PROG_EN = 1'b1;
    logic [BW-1:0] r_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code <= DEFAULT_CODE[BW-1:0];
        end else if (r_state == S_PROG && enter && w_bufFull) begin
            r_code <= r_buf;
        end
    end

    assign w_code = r_code;
`else
    localparam bit PROG_EN = 1'b0;
    assign w_code = DEFAULT_CODE[BW-1:0];
`endif

    // A key counts only on a clean press: exactly one line low after a fully released keypad.
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (!key_n[i]) w_digit = 4'(i);
        end
    end

    assign w_keyEvent  = $onehot(~key_n) && (r_prevKey == 10'h3FF);
    assign w_bufFull   = (r_cnt == CNT_FULL);
    assign w_timeout   = (r_idleCnt == IDLE_LAST);
    assign w_codeMatch = (r_buf == w_code);
    assign w_failNext  = r_failCnt + 4'd1;

    if (DIGITS > 1) begin : g_shift
        assign w_bufShift = {r_buf[BW-5:0], w_digit};
    end else begin : g_single
        assign w_bufShift = w_digit;
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fire)     w_nextState = S_ERROR;
                else if (arm) w_nextState = S_ARMED;
            end
            S_ARMED: begin
                if (fire || enter) begin
                    w_nextState = S_ERROR;
                end else if (disarm) begin
                    w_nextState = S_IDLE;
                end else if (w_keyEvent) begin
                    w_nextState = S_ENTRY;
                    w_accept    = 1'b1;
                end
            end
            S_ENTRY: begin
                if (fire) begin
                    w_nextState = S_ERROR;
                end else if (enter) begin
                    w_nextState = w_bufFull ? S_CHECK : S_ERROR;
                end else if (disarm) begin
                    w_nextState = S_IDLE;
                end else if (w_keyEvent) begin
                    if (w_bufFull) w_nextState = S_ERROR;
                    else           w_accept    = 1'b1;
                end else if (w_timeout) begin
                    w_nextState = S_IDLE;
                end
            end
            S_CHECK: begin
                if (w_codeMatch)                  w_nextState = S_OK;
                else if (w_failNext >= TRIES_MAX) w_nextState = S_LOCKED;
                else                              w_nextState = S_ERROR;
            end
            S_OK: begin
                if (fire)                 w_nextState = S_FIRE;
                else if (prog && PROG_EN) w_nextState = S_PROG;
                else if (disarm)          w_nextState = S_IDLE;
            end
            S_FIRE:   w_nextState = S_IDLE;
            S_ERROR:  if (clear) w_nextState = S_IDLE;
            S_LOCKED: w_nextState = S_LOCKED;
            S_PROG: begin
                if (enter) begin
                    w_nextState = w_bufFull ? S_IDLE : S_ERROR;
                end else if (disarm) begin
                    w_nextState = S_IDLE;
                end else if (w_keyEvent) begin
                    if (w_bufFull) w_nextState = S_ERROR;
                    else           w_accept    = 1'b1;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    assign w_clearBuf = (w_nextState != r_state) &&
                        (w_nextState inside {S_IDLE, S_ARMED, S_ERROR, S_PROG, S_LOCKED});

    // Indicators are registered off the next state so they line up exactly with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_prevKey <= 10'h3FF;
            r_buf     <= '0;
            r_cnt     <= 4'd0;
            r_disp    <= 4'd0;
            r_failCnt <= 4'd0;
            r_idleCnt <= '0;
            r_ok      <= 1'b0;
            r_fire    <= 1'b0;
            r_err     <= 1'b0;
            r_lock    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_prevKey <= key_n;
            if (w_clearBuf) begin
                r_buf <= '0;
                r_cnt <= 4'd0;
            end else if (w_accept) begin
                r_buf <= w_bufShift;
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_accept) r_disp <= w_digit;
            if (w_nextState != S_ENTRY || w_keyEvent) begin
                r_idleCnt <= '0;
            end else if (!w_timeout) begin
                r_idleCnt <= r_idleCnt + 1'b1;
            end
            if (r_state == S_CHECK) r_failCnt <= w_codeMatch ? 4'd0 : w_failNext;
            r_ok   <= (w_nextState == S_OK);
            r_fire <= (w_nextState == S_FIRE);
            r_err  <= (w_nextState == S_ERROR) || (w_nextState == S_LOCKED);
            r_lock <= (w_nextState == S_LOCKED);
        end
    end

    assign ok_led     = r_ok;
    assign fire_led   = r_fire;
    assign err_led    = r_err;
    assign buzzer     = r_err;
    assign lock_led   = r_lock;
    assign digit_disp = r_disp;
    assign digit_cnt  = r_cnt;

endmodule

// File: doc/param_code_detonator.md
PARAM_CODE_DETONATOR -- requirements
Module: param_code_detonator

Interface
REQ-001 SHALL have parameter DIGITS, default 4, code length in BCD digits (legal 1..8).
REQ-002 SHALL have parameter DEFAULT_CODE, default 32'h0000_2580, BCD code at reset; low 4*DIGITS bits used, MS digit entered first.
REQ-003 SHALL have parameter MAX_TRIES, default 3, consecutive failed checks before lockout (legal 1..15).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000, idle cycles allowed between keys during entry.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 key_n  in  10  keypad 0-9, active-low, one key per bit.
REQ-008 arm, disarm, enter, fire, clear, prog  in  1 each  level controls sampled on clk.
REQ-009 ok_led, fire_led, err_led, buzzer, lock_led  out  1 each  status indicators.
REQ-010 digit_disp  out  4  last accepted digit; digit_cnt  out  4  digits held in entry buffer.

Function
REQ-011 A key event SHALL be a cycle where key_n has exactly one bit low and the registered previous key_n is all ones; other patterns, including multi-key, SHALL be ignored.
REQ-012 States SHALL be IDLE, ARMED, ENTRY, CHECK, OK, FIRE, ERROR, LOCKED, PROG.
REQ-013 IDLE: fire -> ERROR; else arm -> ARMED.
REQ-014 ARMED/ENTRY priority SHALL be fire > enter > disarm > key event > timeout.
REQ-015 ARMED: fire or enter -> ERROR; disarm -> IDLE; key event -> ENTRY, digit shifted in, digit_cnt=1.
REQ-016 ENTRY: key event with digit_cnt<DIGITS shifts digit in, digit_cnt+1; key event with digit_cnt==DIGITS -> ERROR (overflow).
REQ-017 ENTRY: enter with digit_cnt==DIGITS -> CHECK; enter with digit_cnt<DIGITS -> ERROR; fire -> ERROR; disarm -> IDLE.
REQ-018 ENTRY: TIMEOUT_CYC consecutive cycles without key event -> IDLE; idle counter saturates and clears on every key event.
REQ-019 CHECK SHALL last exactly one cycle: buffer==code -> OK and fail count cleared; mismatch -> fail count+1, then LOCKED if it reaches MAX_TRIES, else ERROR.
REQ-020 OK: fire -> FIRE; else prog -> PROG; else disarm -> IDLE.
REQ-021 FIRE SHALL last exactly one cycle then -> IDLE.
REQ-022 ERROR: clear -> IDLE; LOCKED SHALL be left only by rst.
REQ-023 PROG: key events fill buffer as in ENTRY; enter with digit_cnt==DIGITS loads code and -> IDLE; enter short or key overflow -> ERROR (code unchanged); disarm -> IDLE (code unchanged); no timeout.
REQ-024 Entry buffer and digit_cnt SHALL clear on every transition into IDLE, ARMED, ERROR, PROG and LOCKED.
REQ-025 Outputs registered from state: ok_led=OK, fire_led=FIRE, err_led=ERROR|LOCKED, buzzer=ERROR|LOCKED, lock_led=LOCKED.
REQ-026 digit_disp SHALL update the cycle after each accepted key event and hold otherwise.
REQ-027 Fail count SHALL survive ERROR and IDLE; cleared only by successful CHECK or rst.

Reset
REQ-028 rst SHALL force IDLE, all outputs 0, buffer 0, digit_cnt 0, fail count 0, idle counter 0, code=DEFAULT_CODE, previous key_n all ones, immediately and regardless of clk.
REQ-029 rst asserted mid-entry or mid-PROG SHALL discard partial input and keep code at DEFAULT_CODE.

Configuration
REQ-030 Macro CODE_PROG_EN defined: PROG state and code register present per REQ-020/023.
REQ-031 CODE_PROG_EN undefined: prog ignored, PROG unreachable, code constant DEFAULT_CODE.

Verification (DIGITS=4, DEFAULT_CODE=2580, MAX_TRIES=3, TIMEOUT_CYC=16)
REQ-032 arm, keys 2,5,8,0, enter -> CHECK one cycle, ok_led=1; fire -> fire_led=1 exactly one cycle, then IDLE.
REQ-033 arm, keys 1,2,3,4, enter, clear, repeated three times -> err_led twice, third attempt lock_led=1, buzzer=1, clear ignored until rst.
REQ-034 arm, keys 2,5,8, enter -> ERROR; arm, keys 2,5,8,0,1 -> ERROR on fifth key; key 5 held 10 cycles counts once.
REQ-035 arm, key 2, then 16 idle cycles -> IDLE, digit_cnt=0; rst pulse mid-entry -> IDLE, all outputs 0.
REQ-036 CODE_PROG_EN: correct 2580 entry, prog, keys 1,3,5,7, enter -> IDLE; 2580 now fails, 1357 gives ok_led=1; without macro 1357 fails.
